// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types, constants and address decode for apb_slave_regfile.
//   apb_slv_state_t : slave FSM state encoding
//   WAIT_CNT_W      : width of the wait-state counter (wait_states 0..15)
//   apb_slv_decode  : byte address -> register index + error flag
package apb_slv_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_slv_state_t;

   localparam int unsigned WAIT_CNT_W = 4;
   localparam int unsigned DEC_IDX_W  = 8;   // enough for num_regs up to 256

   typedef struct packed {
      logic                 err;
      logic [DEC_IDX_W-1:0] idx;
   } apb_slv_dec_t;

   // Word index from addr[..:2]; error on misalignment or beyond the bank.
   function automatic apb_slv_dec_t apb_slv_decode(input logic [63:0] addr,
                                                   input int unsigned nregs);
      apb_slv_dec_t d;
      d.idx = DEC_IDX_W'((addr >> 2) & 64'(nregs - 1));
      d.err = (addr[1:0] != 2'b00) || (addr >= (64'(nregs) << 2));
      return d;
   endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// apb_slv_regbank: register array for apb_slave_regfile.
//   i_clk_apb, i_rst_apb : clock, async active-high reset (clears all registers)
//   i_we, i_widx, i_wdata : write port
//   i_ridx, o_rdata       : read mux
//   o_regs                : all registers flattened, reg k at [k*data_width +: data_width]
module apb_slv_regbank #(
   parameter int unsigned data_width = 32,
   parameter int unsigned num_regs   = 16,
   parameter int unsigned idx_w      = $clog2(num_regs)
) (
   input  logic                           i_clk_apb,
   input  logic                           i_rst_apb,
   input  logic                           i_we,
   input  logic [idx_w-1:0]               i_widx,
   input  logic [data_width-1:0]          i_wdata,
   input  logic [idx_w-1:0]               i_ridx,
   output logic [data_width-1:0]          o_rdata,
   output logic [num_regs*data_width-1:0] o_regs
);

   logic [data_width-1:0] regs_q [num_regs];

   // Storage with single write port.
   always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
      if (i_rst_apb) begin
         for (int unsigned k = 0; k < num_regs; k++) regs_q[k] <= '0;
      end else if (i_we) begin
         regs_q[i_widx] <= i_wdata;
      end
   end

   assign o_rdata = regs_q[i_ridx];

   // Flatten for downstream consumers.
   for (genvar g = 0; g < num_regs; g++) begin : g_flat
      assign o_regs[g*data_width +: data_width] = regs_q[g];
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB slave terminating word transfers into a register bank.
//   i_clk_apb, i_rst_apb     : clock, async active-high reset
//   i_psel, i_penable        : APB select / access phase
//   i_pwrite, i_paddr, i_pwdata : transfer direction, byte address, write data
//   o_prdata, o_pready, o_pslverr : response, all zero unless o_pready=1
//   o_regs                   : flattened register contents
// Optional build macro APB_SLV_WRITE_LOCK_EN: register 0 bit 0 locks writes to
// all other registers; only bit 0 of register 0 is stored.
module apb_slave_regfile
   import apb_slv_pkg::*;
#(
   parameter int unsigned addr_width  = 32,
   parameter int unsigned data_width  = 32,
   parameter int unsigned num_regs    = 16,
   parameter int unsigned wait_states = 0
) (
   input  logic                           i_clk_apb,
   input  logic                           i_rst_apb,
   input  logic                           i_psel,
   input  logic                           i_penable,
   input  logic                           i_pwrite,
   input  logic [addr_width-1:0]          i_paddr,
   input  logic [data_width-1:0]          i_pwdata,
   output logic [data_width-1:0]          o_prdata,
   output logic                           o_pready,
   output logic                           o_pslverr,
   output logic [num_regs*data_width-1:0] o_regs
);

   localparam int unsigned IDX_W = $clog2(num_regs);

   apb_slv_state_t        state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [addr_width-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [data_width-1:0] pwdata_q, pwdata_d;
   logic                  done_c;
   apb_slv_dec_t          dec_c;
   logic [IDX_W-1:0]      idx_c;
   logic                  lock_blk_c;
   logic                  err_c;
   logic                  we_c;
   logic [data_width-1:0] wr_data_c;
   logic [data_width-1:0] rdata_c;

   // State, wait counter and latched setup-phase fields.
   always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
      if (i_rst_apb) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
      end
   end

   // Next state; done_c marks the completing ACCESS cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      done_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_psel && !i_penable) begin
               paddr_d  = i_paddr;
               pwrite_d = i_pwrite;
               pwdata_d = i_pwdata;
               cnt_d    = WAIT_CNT_W'(wait_states);
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!i_psel) begin
               state_d = IDLE;          // abort: no write, no response
            end else if (i_penable) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - WAIT_CNT_W'(1);
               end else begin
                  done_c  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   assign dec_c = apb_slv_decode(64'(paddr_q), num_regs);
   assign idx_c = IDX_W'(dec_c.idx);

`ifdef APB_SLV_WRITE_LOCK_EN
   // Register 0 holds only the lock bit; it blocks writes to every other index.
   assign lock_blk_c = o_regs[0] && (idx_c != '0);
   assign wr_data_c  = (idx_c == '0) ? data_width'(pwdata_q[0]) : pwdata_q;
`else
   assign lock_blk_c = 1'b0;
   assign wr_data_c  = pwdata_q;
`endif

   assign err_c     = dec_c.err || (pwrite_q && lock_blk_c);
   assign we_c      = done_c && pwrite_q && !err_c;
   assign o_pready  = done_c;
   assign o_pslverr = done_c && err_c;
   assign o_prdata  = (done_c && !pwrite_q && !dec_c.err) ? rdata_c : '0;

   apb_slv_regbank #(
      .data_width (data_width),
      .num_regs   (num_regs)
   ) u_regbank (
      .i_clk_apb (i_clk_apb),
      .i_rst_apb (i_rst_apb),
      .i_we      (we_c),
      .i_widx    (idx_c),
      .i_wdata   (wr_data_c),
      .i_ridx    (idx_c),
      .o_rdata   (rdata_c),
      .o_regs    (o_regs)
   );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 3 and 2 wait states) share the
// APB bus, each with its own psel; expectations come from a per-instance word-array model.
module tb_apb_slave_regfile;

   logic          clk = 1'b0;
   logic          rst;
   logic          rst_x;
   logic          psel, penable, pwrite;
   logic [31:0]   paddr, pwdata;
   int            tgt;
   logic          psel_a, psel_b, psel_c;
   logic [31:0]   prdata_a, prdata_b, prdata_c;
   logic          pready_a, pready_b, pready_c;
   logic          pslverr_a, pslverr_b, pslverr_c;
   logic [511:0]  regs_a, regs_b, regs_c;
   logic [31:0]   prdata_m;
   logic          pready_m, pslverr_m;
   logic [511:0]  regs_m;

   logic [31:0]   mdl [3][16];
   int            ws_of [3] = '{0, 3, 2};
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   assign psel_a = psel && (tgt == 0);
   assign psel_b = psel && (tgt == 1);
   assign psel_c = psel && (tgt == 2);

   assign prdata_m  = (tgt == 0) ? prdata_a  : (tgt == 1) ? prdata_b  : prdata_c;
   assign pready_m  = (tgt == 0) ? pready_a  : (tgt == 1) ? pready_b  : pready_c;
   assign pslverr_m = (tgt == 0) ? pslverr_a : (tgt == 1) ? pslverr_b : pslverr_c;
   assign regs_m    = (tgt == 0) ? regs_a    : (tgt == 1) ? regs_b    : regs_c;

   apb_slave_regfile #(.wait_states(0)) dut_a (
      .i_clk_apb(clk), .i_rst_apb(rst), .i_psel(psel_a), .i_penable(penable),
      .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
      .o_prdata(prdata_a), .o_pready(pready_a), .o_pslverr(pslverr_a), .o_regs(regs_a));

   apb_slave_regfile #(.wait_states(3)) dut_b (
      .i_clk_apb(clk), .i_rst_apb(rst), .i_psel(psel_b), .i_penable(penable),
      .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
      .o_prdata(prdata_b), .o_pready(pready_b), .o_pslverr(pslverr_b), .o_regs(regs_b));

   apb_slave_regfile #(.wait_states(2)) dut_c (
      .i_clk_apb(clk), .i_rst_apb(rst || rst_x), .i_psel(psel_c), .i_penable(penable),
      .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
      .o_prdata(prdata_c), .o_pready(pready_c), .o_pslverr(pslverr_c), .o_regs(regs_c));

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] flat(input int t);
      logic [511:0] v;
      for (int k = 0; k < 16; k++) v[k*32 +: 32] = mdl[t][k];
      return v;
   endfunction

   // One full APB transfer on instance t, checked against the model.
   task automatic xfer(input int t, input logic w, input logic [31:0] a, input logic [31:0] d);
      int          idx;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          waits;
      bit          done;
      idx     = int'(a[5:2]);
      exp_err = (a[1:0] != 2'b00) || (a >= 32'd64);
`ifdef APB_SLV_WRITE_LOCK_EN
      if (w && idx != 0 && mdl[t][0][0]) exp_err = 1'b1;
`endif
      exp_rd = (w || exp_err) ? 32'd0 : mdl[t][idx];
      @(negedge clk);
      tgt = t; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1; paddr = $urandom; pwdata = $urandom;   // must be ignored
      waits = 0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         if (pready_m) done = 1'b1;
         else begin
            chk("wait_quiet", {pslverr_m, prdata_m}, '0);
            waits++;
            @(negedge clk);
         end
      end
      chk("pready_seen", done, 1'b1);
      chk("wait_cycles", waits, ws_of[t]);
      chk("pslverr", pslverr_m, exp_err);
      chk("prdata", prdata_m, exp_rd);
      if (w && !exp_err) begin
`ifdef APB_SLV_WRITE_LOCK_EN
         mdl[t][idx] = (idx == 0) ? {31'd0, d[0]} : d;
`else
         mdl[t][idx] = d;
`endif
      end
      @(posedge clk); #1;
      chk("regs_after", regs_m, flat(t));
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      for (int t = 0; t < 3; t++) for (int k = 0; k < 16; k++) mdl[t][k] = '0;
      rst = 1'b1; rst_x = 1'b0; tgt = 0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pready", {pready_a, pready_b, pready_c}, 3'b000);
      chk("rst_pslverr", {pslverr_a, pslverr_b, pslverr_c}, 3'b000);
      chk("rst_prdata", {prdata_a, prdata_b, prdata_c}, '0);
      chk("rst_regs_a", regs_a, '0);
      chk("rst_regs_c", regs_c, '0);
      rst = 1'b0;

      // Directed basics on the zero-wait instance.
      xfer(0, 1'b0, 32'h0, 32'h0);
      xfer(0, 1'b1, 32'h8, 32'hDEADBEEF);
      xfer(0, 1'b0, 32'h8, 32'h0);
      chk("reg2_slice", regs_a[95:64], 32'hDEADBEEF);
      xfer(0, 1'b1, 32'h40, 32'h12345678);
      xfer(0, 1'b1, 32'h6, 32'h87654321);
      xfer(0, 1'b0, 32'h3C, 32'h0);
      xfer(0, 1'b0, 32'h41, 32'h0);

      // Three wait states.
      xfer(1, 1'b0, 32'h4, 32'h0);
      xfer(1, 1'b1, 32'h4, 32'hA5A5_0F0F);
      xfer(1, 1'b0, 32'h4, 32'h0);

`ifdef APB_SLV_WRITE_LOCK_EN
      xfer(0, 1'b1, 32'h0, 32'h1);
      xfer(0, 1'b1, 32'h4, 32'h55);
      chk("locked_reg1", regs_a[63:32], 32'h0);
      xfer(0, 1'b1, 32'h0, 32'h0);
      xfer(0, 1'b1, 32'h4, 32'h55);
      chk("unlocked_reg1", regs_a[63:32], 32'h55);
      xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFE);
      xfer(0, 1'b0, 32'h0, 32'h0);
`endif

      // Protocol abort on the 3-wait instance: psel drops after one ACCESS cycle.
      @(negedge clk);
      tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h1234;
      @(negedge clk); penable = 1'b1; #1;
      chk("abort_pready0", pready_b, 1'b0);
      @(negedge clk); psel = 1'b0; penable = 1'b0;
      repeat (5) begin @(negedge clk); #1; chk("abort_quiet", pready_b, 1'b0); end
      chk("abort_regs", regs_b, flat(1));

      // Reset in the second ACCESS cycle of a 2-wait write.
      @(negedge clk);
      tgt = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hCAFEF00D;
      @(negedge clk); penable = 1'b1; #1;
      chk("mid_acc1", pready_c, 1'b0);
      @(negedge clk); #1;
      chk("mid_acc2", pready_c, 1'b0);
      rst_x = 1'b1; #1;
      chk("mid_rst_pready", pready_c, 1'b0);
      @(negedge clk); rst_x = 1'b0;
      repeat (4) begin @(negedge clk); #1; chk("post_rst_idle", pready_c, 1'b0); end
      chk("post_rst_regs", regs_c, '0);
      psel = 1'b0; penable = 1'b0;
      for (int k = 0; k < 16; k++) mdl[2][k] = '0;
      xfer(2, 1'b0, 32'h8, 32'h0);
      xfer(2, 1'b1, 32'h8, 32'h0BAD_CAFE);
      xfer(2, 1'b0, 32'h8, 32'h0);

      // Randomized traffic, back-to-back, over all instances.
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
         else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
         else             a = 32'h40 + (32'($urandom_range(0, 63)) << 2);
         xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), a, $urandom);
      end
      @(negedge clk); psel = 1'b0; penable = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
